// File: rtl/ex_muldiv_unit_if.sv
// Request/response bundle between the EX stage and the iterative mul/div unit.
// Requests carry forwarded operands; responses return on a valid/ready pair.
interface ex_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            flush;
  logic            busy;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;

  modport master (
    output req_valid, req_op, req_a, req_b,
    output flush, resp_ready,
    input  req_ready, busy, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    input  flush, resp_ready,
    output req_ready, busy, resp_valid, resp_data
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit beside the EX-stage ALU.
// Shift-add multiply and restoring divide, BITS_PER_CYCLE bits per step.
module ex_muldiv_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic             clk,
  input logic             rst,
  ex_muldiv_unit_if.slave bus
);
  localparam int BPC   = BITS_PER_CYCLE;
  localparam int STEPS = XLEN / BPC;
  localparam int CW    = $clog2(STEPS + 1);
  localparam int MW    = XLEN + BPC;
  localparam int PW    = 2*XLEN + BPC;

  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);
  localparam logic [XLEN-1:0] SMIN =
    {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic              rneg_q, rneg_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic            accept;
  logic            a_sgn, b_sgn;
  logic            sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf;
  logic            special;
  logic [XLEN-1:0] sp_res;

  assign accept = bus.req_valid & ~bus.flush
                & (state_q == IDLE);

  assign a_sgn = (bus.req_op == 3'd1)
               | (bus.req_op == 3'd2)
               | (bus.req_op == 3'd4)
               | (bus.req_op == 3'd6);
  assign b_sgn = (bus.req_op == 3'd1)
               | (bus.req_op == 3'd4)
               | (bus.req_op == 3'd6);

  assign sa    = a_sgn & bus.req_a[XLEN-1];
  assign sb    = b_sgn & bus.req_b[XLEN-1];
  assign mag_a = sa ? -bus.req_a : bus.req_a;
  assign mag_b = sb ? -bus.req_b : bus.req_b;

  assign div_zero = bus.req_op[2]
                  & (bus.req_b == '0);
  assign div_ovf  = bus.req_op[2] & ~bus.req_op[0]
                  & (bus.req_a == SMIN)
                  & (&bus.req_b);
  assign special  = div_zero | div_ovf;

  always_comb begin
    sp_res = bus.req_a;
    unique case (1'b1)
      div_zero & bus.req_op[1]:  sp_res = bus.req_a;
      div_zero & ~bus.req_op[1]: sp_res = '1;
      ~div_zero & bus.req_op[1]: sp_res = '0;
      default:                   sp_res = bus.req_a;
    endcase
  end

  // Multiply: low acc bits hold the remaining multiplier digits.
  logic [MW-1:0]     pp;
  logic [PW-1:0]     psum;
  logic [2*XLEN-1:0] prod_n;

  always_comb begin
    pp     = MW'(b_q) * MW'(acc_q[BPC-1:0]);
    psum   = PW'(acc_q) + {pp, {XLEN{1'b0}}};
    prod_n = (2*XLEN)'(psum >> BPC);
  end

  // Divide: acc low half shifts dividend out and quotient in.
  logic [XLEN:0]   r;
  logic [XLEN-1:0] q;

  always_comb begin
    r = rem_q;
    q = acc_q[XLEN-1:0];
    for (int i = 0; i < BPC; i++) begin
      r = {r[XLEN-1:0], q[XLEN-1]};
      q = {q[XLEN-2:0], 1'b0};
      if (r >= {1'b0, b_q}) begin
        r    = r - {1'b0, b_q};
        q[0] = 1'b1;
      end
    end
  end

  logic [2*XLEN-1:0] prod_f;
  logic [XLEN-1:0]   quo_f, rem_f;
  logic [XLEN-1:0]   calc_res;

  assign prod_f = neg_q  ? -prod_n : prod_n;
  assign quo_f  = neg_q  ? -q : q;
  assign rem_f  = rneg_q ? -r[XLEN-1:0]
                         : r[XLEN-1:0];

  always_comb begin
    calc_res = quo_f;
    unique case (1'b1)
      op_q == 3'd0:
        calc_res = prod_f[XLEN-1:0];
      ~op_q[2] & (op_q != 3'd0):
        calc_res = prod_f[2*XLEN-1:XLEN];
      op_q[2] & op_q[1]:
        calc_res = rem_f;
      default:
        calc_res = quo_f;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    b_d     = b_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d   = bus.req_op;
          neg_d  = sa ^ sb;
          rneg_d = sa;
          b_d    = mag_b;
          acc_d  = {{XLEN{1'b0}}, mag_a};
          rem_d  = '0;
          cnt_d  = '0;
          if (special) begin
            state_d = DONE;
            res_d   = sp_res;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (op_q[2]) begin
            acc_d = {acc_q[2*XLEN-1:XLEN], q};
            rem_d = r;
          end else begin
            acc_d = prod_n;
          end
          if (cnt_q == LAST) begin
            state_d = DONE;
            res_d   = calc_res;
          end
        end
      end
      DONE: begin
        if (bus.flush | bus.resp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      b_q     <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == DONE);
  assign bus.busy       = (state_q == CALC)
                        | ((state_q == DONE)
                           & ~bus.resp_ready);
  assign bus.resp_data  = res_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: two instances (1 and 4 bits/step) on shared
// stimulus, checked every cycle against a transaction-level model.
module tb_ex_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_a = 32'h0;
  logic [31:0] req_b = 32'h0;
  logic        flush = 1'b0;
  logic        resp_ready = 1'b0;

  int cmp_n  = 0;
  int fail_n = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ex_muldiv_unit_if #(.XLEN(32)) bus1();
  ex_muldiv_unit_if #(.XLEN(32)) bus4();

  assign bus1.req_valid  = req_valid;
  assign bus1.req_op     = req_op;
  assign bus1.req_a      = req_a;
  assign bus1.req_b      = req_b;
  assign bus1.flush      = flush;
  assign bus1.resp_ready = resp_ready;
  assign bus4.req_valid  = req_valid;
  assign bus4.req_op     = req_op;
  assign bus4.req_a      = req_a;
  assign bus4.req_b      = req_b;
  assign bus4.flush      = flush;
  assign bus4.resp_ready = resp_ready;

  ex_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) u1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  ex_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) u4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );

  logic [1:0]  o_rv, o_rr, o_busy;
  logic [31:0] o_rd [2];
  assign o_rv    = {bus4.resp_valid, bus1.resp_valid};
  assign o_rr    = {bus4.req_ready, bus1.req_ready};
  assign o_busy  = {bus4.busy, bus1.busy};
  assign o_rd[0] = bus1.resp_data;
  assign o_rd[1] = bus4.resp_data;

  function automatic logic [31:0] ref_res(
    input logic [2:0] op, input logic [31:0] a,
    input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic [31:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    p = 64'h0;
    res = 32'h0;
    case (op)
      3'd0: begin p = sa * sb; res = p[31:0]; end
      3'd1: begin p = sa * sb; res = p[63:32]; end
      3'd2: begin p = sa * ub; res = p[63:32]; end
      3'd3: begin p = ua * ub; res = p[63:32]; end
      3'd4: begin
        if (b == 0) res = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) res = a;
        else begin p = sa / sb; res = p[31:0]; end
      end
      3'd5: res = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) res = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) res = 0;
        else begin p = sa % sb; res = p[31:0]; end
      end
      default: res = (b == 0) ? a : a % b;
    endcase
    return res;
  endfunction

  function automatic bit is_special(
    input logic [2:0] op, input logic [31:0] a,
    input logic [31:0] b);
    if (!op[2]) return 1'b0;
    if (b == 0) return 1'b1;
    return (op == 3'd4 || op == 3'd6)
        && a == 32'h80000000 && b == 32'hFFFFFFFF;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      fail_n++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Transaction-level model: one pending op per instance.
  int          bpcs [2] = '{1, 4};
  bit          m_pend [2];
  int          m_cyc [2];
  int          m_lat [2];
  logic [31:0] m_exp [2];
  logic [31:0] m_last [2];

  always @(posedge clk or negedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        m_pend[d] <= 1'b0;
        m_cyc[d]  <= 0;
        m_last[d] <= 32'h0;
      end else if (m_pend[d]) begin
        if (flush) begin
          m_pend[d] <= 1'b0;
          if (m_cyc[d] >= m_lat[d]) m_last[d] <= m_exp[d];
        end else if (m_cyc[d] >= m_lat[d] && resp_ready) begin
          m_pend[d] <= 1'b0;
          m_last[d] <= m_exp[d];
        end else begin
          m_cyc[d] <= m_cyc[d] + 1;
        end
      end else if (req_valid && !flush) begin
        m_pend[d] <= 1'b1;
        m_cyc[d]  <= 1;
        m_exp[d]  <= ref_res(req_op, req_a, req_b);
        m_lat[d]  <= is_special(req_op, req_a, req_b)
                     ? 1 : 32 / bpcs[d] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        string u;
        u = (d == 0) ? "u1" : "u4";
        if (!m_pend[d]) begin
          chk({u, " idle resp_valid"}, 32'(o_rv[d]), 0);
          chk({u, " idle busy"}, 32'(o_busy[d]), 0);
          chk({u, " idle req_ready"}, 32'(o_rr[d]), 1);
          chk({u, " idle resp_data"}, o_rd[d], m_last[d]);
        end else if (m_cyc[d] < m_lat[d]) begin
          chk({u, " calc resp_valid"}, 32'(o_rv[d]), 0);
          chk({u, " calc busy"}, 32'(o_busy[d]), 1);
          chk({u, " calc req_ready"}, 32'(o_rr[d]), 0);
        end else begin
          chk({u, " done resp_valid"}, 32'(o_rv[d]), 1);
          chk({u, " done resp_data"}, o_rd[d], m_exp[d]);
          chk({u, " done busy"}, 32'(o_busy[d]), 32'(!resp_ready));
          chk({u, " done req_ready"}, 32'(o_rr[d]), 0);
        end
      end
    end
  end

  task automatic run(input logic [2:0] op,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input int hold,
                     output logic [31:0] d1,
                     output int l1, output int l4);
    int cyc;
    bit g1, g4;
    g1 = 0; g4 = 0; l1 = 0; l4 = 0; d1 = 32'h0;
    req_op = op; req_a = a; req_b = b;
    req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    while (!(g1 && g4) && cyc < 100) begin
      if (bus1.resp_valid && !g1) begin
        g1 = 1; l1 = cyc; d1 = bus1.resp_data;
      end
      if (bus4.resp_valid && !g4) begin
        g4 = 1; l4 = cyc;
      end
      if (!(g1 && g4)) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!(g1 && g4)) begin
      cmp_n++; fail_n++;
      $display("FAIL resp timeout: got none want resp_valid");
    end
    repeat (hold) begin @(posedge clk); #1; end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic run_flush(input logic [2:0] op,
                           input logic [31:0] a,
                           input logic [31:0] b,
                           input int at, input int after);
    int cyc;
    bit saw;
    req_op = op; req_a = a; req_b = b;
    req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    while (cyc < at) begin
      @(posedge clk); #1;
      cyc++;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush u1 req_ready", 32'(bus1.req_ready), 1);
    chk("flush u4 req_ready", 32'(bus4.req_ready), 1);
    saw = 0;
    repeat (after) begin
      @(posedge clk); #1;
      if (bus1.resp_valid || bus4.resp_valid) saw = 1;
    end
    chk("flush no resp", 32'(saw), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int l1, l4;
    bit saw;
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    #1;
    chk("reset req_ready", 32'(bus1.req_ready), 1);
    chk("reset busy", 32'(bus1.busy), 0);
    chk("reset resp_valid", 32'(bus4.resp_valid), 0);
    chk("reset resp_data", bus1.resp_data, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    run(3'd0, 32'd7, 32'hFFFFFFFD, 0, d, l1, l4);
    chk("MUL data", d, 32'hFFFFFFEB);
    chk("MUL lat bpc1", l1, 33);
    chk("MUL lat bpc4", l4, 9);
    run(3'd1, 32'h80000000, 32'h80000000, 0, d, l1, l4);
    chk("MULH data", d, 32'h40000000);
    run(3'd2, 32'hFFFFFFFF, 32'd2, 0, d, l1, l4);
    chk("MULHSU data", d, 32'hFFFFFFFF);
    run(3'd3, 32'hFFFFFFFF, 32'd2, 0, d, l1, l4);
    chk("MULHU data", d, 32'h00000001);
    run(3'd4, 32'hFFFFFFF9, 32'd2, 0, d, l1, l4);
    chk("DIV data", d, 32'hFFFFFFFD);
    run(3'd6, 32'hFFFFFFF9, 32'd2, 0, d, l1, l4);
    chk("REM data", d, 32'hFFFFFFFF);
    run(3'd5, 32'd100, 32'd0, 0, d, l1, l4);
    chk("DIVU /0 data", d, 32'hFFFFFFFF);
    chk("DIVU /0 lat", l1, 1);
    run(3'd4, 32'h80000000, 32'hFFFFFFFF, 0, d, l1, l4);
    chk("DIV ovf data", d, 32'h80000000);
    chk("DIV ovf lat", l1, 1);
    run(3'd6, 32'h80000000, 32'hFFFFFFFF, 0, d, l1, l4);
    chk("REM ovf data", d, 32'h0);
    chk("REM ovf lat bpc4", l4, 1);

    run(3'd0, 32'd12345, 32'd678, 5, d, l1, l4);
    chk("hold data", d, 32'd8369910);
    chk("hold release idle", 32'(bus1.req_ready), 1);

    run_flush(3'd0, 32'd7, 32'hFFFFFFFD, 10, 40);

    req_op = 3'd0; req_a = 32'd3; req_b = 32'd5;
    req_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    chk("idle flush no accept", 32'(bus1.busy), 0);

    req_op = 3'd5; req_a = 32'd1000; req_b = 32'd7;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    chk("mid reset busy", 32'(bus1.busy), 0);
    chk("mid reset resp_data", bus1.resp_data, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    saw = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus1.resp_valid || bus4.resp_valid) saw = 1;
    end
    chk("mid reset no resp", 32'(saw), 0);

    for (int k = 0; k < 150; k++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      int mode;
      op = 3'($urandom_range(0, 7));
      mode = $urandom_range(0, 5);
      a = $urandom;
      b = $urandom;
      case (mode)
        1: b = 32'h0;
        2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        3: begin
          a = 32'($signed($urandom_range(0, 40)) - 20);
          b = 32'($signed($urandom_range(0, 40)) - 20);
        end
        4: b = 32'($urandom_range(1, 3));
        default: ;
      endcase
      if ($urandom_range(0, 7) == 0) begin
        run_flush(op, a, b, $urandom_range(1, 40), 2);
      end else begin
        run(op, a, b, $urandom_range(0, 2), d, l1, l4);
        chk("rand data", d, ref_res(op, a, b));
      end
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp_n, fail_n);
    $finish;
  end
endmodule
